// File: rtl/seq_alu_ctrl_if.sv
// Request/response bundle for the sequential ALU controller.
// The master drives an operation request and the slave returns status and result.
interface seq_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   ovf;
    logic                   dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, result, ovf, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, ovf, dbz
    );
endinterface

// File: rtl/seq_alu_ctrl.sv
// Multi-cycle ALU: add/sub in one step, radix-2 Booth signed multiply,
// and non-restoring unsigned divide. All outputs are registered.
module seq_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_alu_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [6:0] {
        IDLE     = 7'b0000001,
        LOAD     = 7'b0000010,
        ADDSUB   = 7'b0000100,
        MUL      = 7'b0001000,
        DIV      = 7'b0010000,
        DIV_CORR = 7'b0100000,
        DONE     = 7'b1000000
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    // Accumulator and divisor carry one guard bit so that M = -2^(WIDTH-1) and
    // the non-restoring partial remainder both stay representable.
    logic [WIDTH:0]         acc_q;
    logic [WIDTH-1:0]       q_q;
    logic [WIDTH:0]         m_q;
    logic                   qm1_q;
    logic [CW-1:0]          cnt_q;
    logic [2*WIDTH-1:0]     result_q;
    logic                   ovf_q;
    logic                   dbz_q;
    logic                   busy_q;
    logic                   done_q;

    logic [WIDTH:0]         as_sum_s;
    logic                   as_ovf_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [WIDTH:0]         mul_acc_d;
    logic [WIDTH-1:0]       mul_q_d;
    logic                   mul_qm1_d;
    logic [WIDTH:0]         div_sh_s;
    logic [WIDTH:0]         div_acc_d;
    logic [WIDTH-1:0]       div_q_d;
    logic [WIDTH:0]         corr_acc_d;
    logic                   last_step_s;

    // Datapath step values for every arithmetic state
    always_comb begin
        as_sum_s    = {WIDTH+1{1'b0}};
        mul_sum_s   = acc_q;
        div_sh_s    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_acc_d   = {WIDTH+1{1'b0}};
        corr_acc_d  = acc_q;

        if (op_q[0]) begin
            as_sum_s = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
        end else begin
            as_sum_s = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
        end
        as_ovf_s = as_sum_s[WIDTH] ^ as_sum_s[WIDTH-1];

        case ({q_q[0], qm1_q})
            2'b10:   mul_sum_s = acc_q - m_q;
            2'b01:   mul_sum_s = acc_q + m_q;
            default: mul_sum_s = acc_q;
        endcase
        mul_acc_d = {mul_sum_s[WIDTH], mul_sum_s[WIDTH:1]};
        mul_q_d   = {mul_sum_s[0], q_q[WIDTH-1:1]};
        mul_qm1_d = q_q[0];

        // Add/subtract choice follows the sign of the remainder before the shift
        if (acc_q[WIDTH]) begin
            div_acc_d = div_sh_s + m_q;
        end else begin
            div_acc_d = div_sh_s - m_q;
        end
        div_q_d = {q_q[WIDTH-2:0], ~div_acc_d[WIDTH]};

        if (acc_q[WIDTH]) begin
            corr_acc_d = acc_q + m_q;
        end else begin
            corr_acc_d = acc_q;
        end

        last_step_s = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH+1{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            m_q      <= {WIDTH+1{1'b0}};
            qm1_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            result_q <= {2*WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    acc_q <= {WIDTH+1{1'b0}};
                    q_q   <= a_q;
                    qm1_q <= 1'b0;
                    cnt_q <= {CW{1'b0}};
                    if (op_q == 2'b10) begin
                        m_q <= {b_q[WIDTH-1], b_q};
                    end else begin
                        m_q <= {1'b0, b_q};
                    end
                    case (op_q)
                        2'b10: state_q <= MUL;
                        2'b11: begin
                            if (b_q == {WIDTH{1'b0}}) begin
                                result_q <= {a_q, {WIDTH{1'b1}}};
                                ovf_q    <= 1'b0;
                                dbz_q    <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                state_q  <= DIV;
                            end
                        end
                        default: state_q <= ADDSUB;
                    endcase
                end
                ADDSUB: begin
                    result_q <= {{(WIDTH-1){as_sum_s[WIDTH]}}, as_sum_s};
                    ovf_q    <= as_ovf_s;
                    dbz_q    <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    q_q   <= mul_q_d;
                    qm1_q <= mul_qm1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step_s) begin
                        result_q <= {mul_acc_d[WIDTH-1:0], mul_q_d};
                        ovf_q    <= 1'b0;
                        dbz_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_d;
                    q_q   <= div_q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step_s) begin
                        state_q <= DIV_CORR;
                    end
                end
                DIV_CORR: begin
                    acc_q    <= corr_acc_d;
                    result_q <= {corr_acc_d[WIDTH-1:0], q_q};
                    ovf_q    <= 1'b0;
                    dbz_q    <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.dbz    = dbz_q;
endmodule

// File: tb/tb_seq_alu_ctrl.sv
// Self-checking bench for seq_alu_ctrl (WIDTH=8): vector table, latency
// checks, busy/done-time start pulses and a mid-multiply reset.
module tb_seq_alu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_ctrl_if #(.WIDTH(8)) bus ();

    seq_alu_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", bus.result, e.res);
                chk("ovf", bus.ovf, e.ovf);
                chk("dbz", bus.dbz, e.dbz);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] res, input logic ovf, input logic dbz,
                          input int lat, input bit pulse_busy, input bit start_in_done);
        int  edges;
        bit  seen;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.res = res; e.ovf = ovf; e.dbz = dbz;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, 1'b1);
        edges = 1;
        seen  = 1'b0;
        while (edges < 60 && !seen) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (pulse_busy && edges == 4) begin
                    bus.start = 1'b1;
                    bus.op    = 2'b00;
                    bus.a     = 8'h01;
                    bus.b     = 8'h01;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                edges++;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", seen, 1'b1);
        chk("latency", edges, lat);
        if (start_in_done) begin
            bus.start = 1'b1;
            bus.op    = 2'b00;
            bus.a     = 8'h11;
            bus.b     = 8'h22;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
        chk("idle_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        bit        stray;
        vecs[0]  = '{2'b00, 8'd100, 8'd50,  16'h0096, 1'b1, 1'b0, 3};
        vecs[1]  = '{2'b01, 8'd5,   8'd10,  16'hFFFB, 1'b0, 1'b0, 3};
        vecs[2]  = '{2'b10, 8'hF9,  8'd3,   16'hFFEB, 1'b0, 1'b0, 10};
        vecs[3]  = '{2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 11};
        vecs[4]  = '{2'b11, 8'd25,  8'd0,   16'h19FF, 1'b0, 1'b1, 2};
        vecs[5]  = '{2'b00, 8'h80,  8'hFF,  16'hFF7F, 1'b1, 1'b0, 3};
        vecs[6]  = '{2'b01, 8'h7F,  8'hFF,  16'h0080, 1'b1, 1'b0, 3};
        vecs[7]  = '{2'b10, 8'h7F,  8'h80,  16'hC080, 1'b0, 1'b0, 10};
        vecs[8]  = '{2'b11, 8'hFF,  8'h01,  16'h00FF, 1'b0, 1'b0, 11};
        vecs[9]  = '{2'b11, 8'h05,  8'h09,  16'h0500, 1'b0, 1'b0, 11};
        vecs[10] = '{2'b00, 8'hF6,  8'h05,  16'hFFFB, 1'b0, 1'b0, 3};
        vecs[11] = '{2'b10, 8'hFD,  8'hFE,  16'h0006, 1'b0, 1'b0, 10};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_dbz", bus.dbz, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].ovf, vecs[i].dbz, vecs[i].lat, 1'b0, 1'b0);
        end

        // Most-negative squared, with start pulsed while busy and during DONE
        done_cnt = 0;
        run_op(2'b10, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 10, 1'b1, 1'b1);
        repeat (15) @(negedge clk);
        chk("single_done", done_cnt, 1);

        // Reset during the fourth multiply step
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 8'h55;
        bus.b     = 8'h33;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_result", bus.result, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) stray = 1'b1;
        end
        chk("no_done_after_abort", stray, 1'b0);
        chk("result_held_zero", bus.result, 16'h0000);

        run_op(2'b00, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu_ctrl.md
SEQ_ALU_CTRL -- requirements
Module: seq_alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  operation request, sampled in IDLE only.
REQ-005 op  input  2  operation: 00 add, 01 sub, 10 signed multiply (radix-2 Booth), 11 unsigned divide (non-restoring).
REQ-006 a  input  WIDTH  first operand / dividend / multiplicand.
REQ-007 b  input  WIDTH  second operand / divisor / multiplier.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse, high only in state DONE.
REQ-010 result  output  2*WIDTH  registered result; held until the next DONE.
REQ-011 ovf  output  1  signed WIDTH-bit overflow of add/sub; 0 for other ops.
REQ-012 dbz  output  1  divide-by-zero flag of the last operation.

Function
REQ-013 States: IDLE, LOAD, ADDSUB, MUL, DIV, DIV_CORR, DONE; one-hot encoded.
REQ-014 Accept edge E0: IDLE with start=1; a, b, op latched; next state LOAD.
REQ-015 start outside IDLE is ignored; latched operands unaffected.
REQ-016 LOAD (edge E1): init A=0, Q=a, M=b, q_min1=0, cnt=0; go ADDSUB (op 0x), MUL (10), DIV (11, b!=0), DONE (11, b==0).
REQ-017 ADDSUB (edge E2): result = sign-extended (WIDTH+1)-bit signed a+b or a-b; ovf = WIDTH-bit signed overflow; go DONE.
REQ-018 MUL step, one per cycle: {Q[0],q_min1}=10 -> A=A-M; 01 -> A=A+M; 00/11 -> no add; then arithmetic shift right of {A,Q,q_min1}; cnt+1.
REQ-019 MUL exits to DONE on the step where cnt reaches WIDTH-1 (WIDTH steps, edges E2..E(WIDTH+1)); result={A,Q}, signed 2*WIDTH product.
REQ-020 DIV step, one per cycle, A width WIDTH+1: shift {A,Q} left 1; A>=0 -> A=A-M else A=A+M; Q[0]=~A[WIDTH]; cnt+1.
REQ-021 DIV exits to DIV_CORR after WIDTH steps; DIV_CORR: if A<0 then A=A+M; go DONE; result={A[WIDTH-1:0] remainder, Q quotient}.
REQ-022 Divide by zero: result={a, all ones}, dbz=1, no iterations.
REQ-023 dbz and ovf updated together with result at entry to DONE; cleared to 0 for ops that do not set them.
REQ-024 Latency, edges from E0 until done is high: add/sub 3, mul WIDTH+2, div WIDTH+3, div-by-zero 2.
REQ-025 DONE always returns to IDLE next edge; start in DONE ignored; new start accepted in IDLE the following cycle.
REQ-026 Multiply operand -2^(WIDTH-1) x -2^(WIDTH-1) yields +2^(2*WIDTH-2) without overflow.
REQ-027 cnt width clog2(WIDTH)+1; no wrap within one operation.

Reset
REQ-028 rst asserted: state IDLE, busy=0, done=0, result=0, ovf=0, dbz=0, internal registers 0, immediately (asynchronous).
REQ-029 rst mid-operation aborts it; no done pulse; result not updated from the aborted op.
REQ-030 After rst release, first rising edge with start=1 is a valid E0.

Verification (WIDTH=8)
REQ-031 op=00, a=100, b=50 -> done after 3 edges, result=16'h0096, ovf=1, dbz=0.
REQ-032 op=01, a=5, b=10 -> result=16'hFFFB, ovf=0; op=10, a=-7, b=3 -> done after 10 edges, result=16'hFFEB.
REQ-033 op=10, a=8'h80, b=8'h80 -> result=16'h4000; start pulsed while busy -> ignored, single done.
REQ-034 op=11, a=200, b=7 -> done after 11 edges, result=16'h041C, dbz=0.
REQ-035 op=11, a=25, b=0 -> done after 2 edges, result=16'h19FF, dbz=1.
REQ-036 rst during MUL step 4 -> busy=0 immediately, no done, result keeps reset value 0; next add completes normally.
